// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - registered flag-op stage with ALU flag merge and internal flag stack
// Status layout [6]DF [5]AF [4]CF [3]PF [2]ZF [1]SF [0]OF; result held in a single-entry output register.
module flag_unit #(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_opnd,
  input  logic              alu_valid,
  input  logic [6:0]        alu_flags,
  input  logic [6:0]        alu_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_ah_wr,
  output logic              out_fault,
  output logic [6:0]        status,
  output logic [CNT_W-1:0]  stack_count
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_CLC   = 4'd1;
  localparam logic [3:0] OP_STC   = 4'd2;
  localparam logic [3:0] OP_CMC   = 4'd3;
  localparam logic [3:0] OP_CLD   = 4'd4;
  localparam logic [3:0] OP_STD   = 4'd5;
  localparam logic [3:0] OP_SAHF  = 4'd6;
  localparam logic [3:0] OP_LAHF  = 4'd7;
  localparam logic [3:0] OP_PUSHF = 4'd8;
  localparam logic [3:0] OP_POPF  = 4'd9;
  localparam logic [3:0] OP_FLUSH = 4'd10;

  // Memory is padded to a power of two so the index width matches exactly.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int MEM_D = 1 << IDX_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  logic [6:0]        stack_mem [MEM_D];
  logic              accept, push, pop, flush;
  logic              n_fault, n_ah;
  logic [6:0]        m, n_status;
  logic [DATA_W-1:0] n_result;
  logic [CNT_W-1:0]  top;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign top      = stack_count - CNT_W'(1);
  assign wr_idx   = stack_count[IDX_W-1:0];
  assign rd_idx   = top[IDX_W-1:0];

  always_comb begin
    m        = alu_valid ? ((status & ~alu_mask) | (alu_flags & alu_mask)) : status;
    n_status = m;
    n_result = in_opnd;
    n_ah     = 1'b0;
    n_fault  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    if (accept) begin
      case (in_op)
        OP_NOP:   ;
        OP_CLC:   n_status[4] = 1'b0;
        OP_STC:   n_status[4] = 1'b1;
        OP_CMC:   n_status[4] = ~m[4];
        OP_CLD:   n_status[6] = 1'b0;
        OP_STD:   n_status[6] = 1'b1;
        OP_SAHF:  n_status[5:1] = {in_opnd[12], in_opnd[8], in_opnd[10], in_opnd[14], in_opnd[15]};
        OP_LAHF: begin
          n_ah            = 1'b1;
          n_result[15:8]  = {m[1], m[2], 1'b0, m[5], 1'b0, m[3], 1'b1, m[4]};
        end
        OP_PUSHF: begin
          if (stack_count == FULL) n_fault = 1'b1;
          else                     push    = 1'b1;
        end
        OP_POPF: begin
          if (stack_count == '0) begin
            n_fault = 1'b1;
          end else begin
            pop      = 1'b1;
            n_status = stack_mem[rd_idx];
          end
        end
        OP_FLUSH: flush = 1'b1;
        default:  n_fault = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status      <= '0;
      stack_count <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ah_wr   <= 1'b0;
      out_fault   <= 1'b0;
    end else begin
      status <= n_status;
      if (flush)     stack_count <= '0;
      else if (push) stack_count <= stack_count + CNT_W'(1);
      else if (pop)  stack_count <= top;
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= n_result;
        out_ah_wr  <= n_ah;
        out_fault  <= n_fault;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Entries above stack_count are dead, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= m;
  end

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - scoreboard bench for flag_unit with a queue-based reference model
module tb_flag_unit;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk, rst, in_valid, in_ready, alu_valid, out_valid, out_ready, out_ah_wr, out_fault;
  logic [3:0]    in_op;
  logic [DW-1:0] in_opnd, out_result;
  logic [6:0]    alu_flags, alu_mask, status;
  logic [CW-1:0] stack_count;

  flag_unit #(.DATA_W(DW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_opnd(in_opnd), .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_mask(alu_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ah_wr(out_ah_wr), .out_fault(out_fault), .status(status), .stack_count(stack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] result; logic ah; logic fault; } exp_t;
  exp_t       sb[$];
  logic [6:0] stk[$];
  logic [6:0] mst = '0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: flags as named bits, stack as a LIFO queue.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mst = '0;
        stk.delete();
        sb.delete();
      end else begin
        logic [6:0] m;
        exp_t e;
        logic [7:0] ah;
        m = mst;
        for (int b = 0; b < 7; b++)
          if (alu_valid && alu_mask[b]) m[b] = alu_flags[b];
        if (in_valid && sb.size() == 0) begin
          e.result = in_opnd; e.ah = 1'b0; e.fault = 1'b0;
          ah = in_opnd[15:8];
          case (in_op)
            0: ;
            1: m[4] = 1'b0;
            2: m[4] = 1'b1;
            3: m[4] = !m[4];
            4: m[6] = 1'b0;
            5: m[6] = 1'b1;
            6: begin m[1] = ah[7]; m[2] = ah[6]; m[5] = ah[4]; m[3] = ah[2]; m[4] = ah[0]; end
            7: begin
              e.ah = 1'b1;
              ah = 8'h02;
              if (m[1]) ah = ah + 8'h80;
              if (m[2]) ah = ah + 8'h40;
              if (m[5]) ah = ah + 8'h10;
              if (m[3]) ah = ah + 8'h04;
              if (m[4]) ah = ah + 8'h01;
              e.result[15:8] = ah;
            end
            8: if (stk.size() >= DEPTH) e.fault = 1'b1; else stk.push_back(m);
            9: if (stk.size() == 0) e.fault = 1'b1; else m = stk.pop_back();
            10: stk.delete();
            default: e.fault = 1'b1;
          endcase
          sb.push_back(e);
        end
        mst = m;
      end
    end
  end

  // Monitor: compares architectural state every cycle and pops on each output handshake.
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", out_valid, sb.size() != 0);
      check("in_ready", in_ready, sb.size() == 0 || out_ready);
      check("status", status, mst);
      check("stack_count", stack_count, stk.size());
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_result", out_result, e.result);
          check("out_ah_wr", out_ah_wr, e.ah);
          check("out_fault", out_fault, e.fault);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [DW-1:0] opnd);
    in_valid = 1'b1; in_op = op; in_opnd = opnd;
    step();
    in_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic alu_set(input logic [6:0] f, input logic [6:0] mk);
    alu_valid = 1'b1; alu_flags = f; alu_mask = mk;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_opnd = 0; alu_valid = 0;
    alu_flags = 0; alu_mask = 0; out_ready = 1'b1;
    step(); step();
    check("rst_status", status, 0);
    check("rst_count", stack_count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_ah_fault", {out_ah_wr, out_fault}, 0);
    rst = 1'b0;
    step();

    send(4'd2, 32'h1); check("stc", status, 7'h10); check("stc_valid", out_valid, 1);
    send(4'd3, 32'h2); check("cmc", status, 7'h00);
    send(4'd5, 32'h3); check("std", status, 7'h40);

    alu_set(7'h01, 7'h01); step(); alu_valid = 0;
    check("pre_sahf", status, 7'h41);
    send(4'd6, 32'h0000_D500);
    check("sahf_status", status, 7'h7F); check("sahf_result", out_result, 32'h0000_D500);

    alu_set(7'h3E, 7'h7F); step(); alu_valid = 0;
    send(4'd7, 32'h1234_0078);
    check("lahf_result", out_result, 32'h1234_D778); check("lahf_ah", out_ah_wr, 1);

    for (int i = 0; i < 5; i++) begin
      alu_set(7'(i + 1), 7'h7F);
      send(4'd8, 32'h0);
      check("push_fault", out_fault, i == 4);
      check("push_count", stack_count, (i == 4) ? 4 : i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(4'd9, 32'h0);
      check("pop_lifo", status, 7'(4 - i));
    end
    send(4'd9, 32'h0);
    check("pop_empty_fault", out_fault, 1); check("pop_empty_status", status, 7'h01);

    alu_set(7'h7F, 7'h10);
    send(4'd1, 32'h0);
    check("clc_vs_alu", status, 7'h01);

    send(4'd8, 32'h0);
    step();
    out_ready = 1'b0;
    send(4'd2, 32'hCAFE_0001);
    in_valid = 1'b1; in_op = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", out_result, 32'hCAFE_0001);
      check("stall_flags", {out_ah_wr, out_fault}, 0);
      check("stall_status", status, 7'h11);
    end
    rst = 1'b1;
    step();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_status", status, 0);
    check("rst_mid_count", stack_count, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) in_op = 4'($urandom_range(8, 9));
      in_opnd   = $urandom;
      alu_valid = ($urandom_range(0, 3) == 0);
      alu_flags = 7'($urandom);
      alu_mask  = 7'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = (c == 300);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; alu_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    check("drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
